// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debouncer.
package debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } debounce_state_t;

  localparam int DEFAULT_BOUNCE_TICKS = 12000;

endpackage

// File: rtl/button_debouncer_synchronizer.sv
// Multi-flop synchroniser for an asynchronous pad input; all flops clear on reset.
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk) begin
    if (!rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Counter-qualified debouncer: a level change is accepted after BOUNCE_TICKS stable clocks.
// Define DEBOUNCE_SYNC_EN to put a 2-flop synchroniser in front of the FSM.
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int BOUNCE_TICKS = DEFAULT_BOUNCE_TICKS
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in,
  output logic       out,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int CNT_W = $clog2(BOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BOUNCE_TICKS - 1);

  logic            in_s;
  debounce_state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic            out_n;

`ifdef DEBOUNCE_SYNC_EN
  synchronizer #(.STAGES(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (in),
    .q   (in_s)
  );
`else
  assign in_s = in;
`endif

  // out is computed from the next state so it flips on the same edge as the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= STABLE_LOW;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      out   <= out_n;
    end
  end

  // A glitch inside a WAIT state drops straight back; no partial count is kept.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      STABLE_LOW: begin
        if (in_s) begin
          state_n = WAIT_HIGH;
          cnt_n   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!in_s) begin
          state_n = STABLE_LOW;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = STABLE_HIGH;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STABLE_HIGH: begin
        if (!in_s) begin
          state_n = WAIT_LOW;
          cnt_n   = '0;
        end
      end
      WAIT_LOW: begin
        if (in_s) begin
          state_n = STABLE_HIGH;
          cnt_n   = '0;
        end else if (cnt == CNT_MAX) begin
          state_n = STABLE_LOW;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = STABLE_LOW;
        cnt_n   = '0;
      end
    endcase
  end

  always_comb begin
    out_n     = (state_n == STABLE_HIGH) || (state_n == WAIT_LOW);
    busy      = (state == WAIT_HIGH) || (state == WAIT_LOW);
    dbg_state = state;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: out edges are scheduled into a queue and
// checked (value and cycle) by an independent monitor.
module tb_button_debouncer;
  import debounce_pkg::*;

  localparam int BT = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif
  localparam int LAT   = BT + 1 + SD;
  localparam int EXP_W = 33;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in  = 1'b0;
  logic       out;
  logic       busy;
  logic [1:0] dbg_state;

  button_debouncer #(.BOUNCE_TICKS(BT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .out       (out),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] e;
  bit   mon_en = 1'b0;
  logic prev_out;
  logic out_d = 1'b0;
  int   pulses = 0;
  int   pulse_base;

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_edge(input logic v, input int at);
    exp_q.push_back({v, 32'(at)});
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive_seq(input logic [7:0] pat, input int len);
    for (int i = len - 1; i >= 0; i--) begin
      in = pat[i];
      step(1);
    end
  endtask

  // scoreboard monitor: every change of out must match the head of exp_q
  always @(negedge clk) begin
    if (mon_en && (out !== prev_out)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_edge: out went to %b at cycle %0d, none expected", out, cyc);
      end else begin
        e = exp_q.pop_front();
        if ((e[32] !== out) || (e[31:0] != 32'(cyc))) begin
          errors++;
          $display("FAIL out_edge: got %b at cycle %0d expected %b at cycle %0d",
                   out, cyc, e[32], e[31:0]);
        end
      end
    end
    prev_out <= out;
  end

  // downstream edge detector model
  always @(posedge clk) out_d <= out;
  always @(negedge clk) if (mon_en && out && !out_d) pulses <= pulses + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check1("reset_out", out, 1'b0);
      check1("reset_busy", busy, 1'b0);
    end
    in  = 1'b0;
    rst = 1'b1;
    step(3);
    mon_en = 1'b1;
    check1("idle_out", out, 1'b0);

    // clean press
    in = 1'b1;
    expect_edge(1'b1, cyc + LAT);
    step(1 + SD);
    check1("press_busy", busy, 1'b1);
    check1("press_out_low", out, 1'b0);
    step(LAT - 1 - SD);
    check1("press_out", out, 1'b1);
    check1("press_busy_done", busy, 1'b0);
    step(2);

    // clean release
    in = 1'b0;
    expect_edge(1'b0, cyc + LAT);
    step(LAT + 2);
    check1("release_out", out, 1'b0);

    // bouncy press 1,0,1,1,0 then held 1
    drive_seq(8'b0001_0110, 5);
    check1("bounce_out_low", out, 1'b0);
    in = 1'b1;
    expect_edge(1'b1, cyc + LAT);
    step(LAT + 2);
    check1("bounce_out", out, 1'b1);
    check1("bounce_busy", busy, 1'b0);

    // release with a one-cycle glitch on the third cycle
    in = 1'b0;
    step(2);
    in = 1'b1;
    step(1);
    in = 1'b0;
    expect_edge(1'b0, cyc + LAT);
    step(2 + SD);
    check1("glitch_busy", busy, 1'b1);
    check1("glitch_out_high", out, 1'b1);
    step(LAT);
    check1("glitch_out", out, 1'b0);

    // reset during WAIT_LOW with out high
    in = 1'b1;
    expect_edge(1'b1, cyc + LAT);
    step(LAT + 2);
    in = 1'b0;
    step(2 + SD);
    check1("midrst_busy_pre", busy, 1'b1);
    check1("midrst_out_pre", out, 1'b1);
    rst = 1'b0;
    expect_edge(1'b0, cyc + 1);
    step(1);
    check1("midrst_out", out, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    rst = 1'b1;
    in  = 1'b1;
    expect_edge(1'b1, cyc + LAT);
    step(LAT - 1);
    check1("post_rst_out_low", out, 1'b0);
    step(1);
    check1("post_rst_out", out, 1'b1);

    // release, then three bouncy presses into the edge detector
    in = 1'b0;
    expect_edge(1'b0, cyc + LAT);
    step(LAT + 2);
    pulse_base = pulses;
    for (int p = 0; p < 3; p++) begin
      drive_seq(8'b0000_1010, 4);
      in = 1'b1;
      expect_edge(1'b1, cyc + LAT);
      step(LAT + 2);
      drive_seq(8'b0000_0101, 4);
      in = 1'b0;
      expect_edge(1'b0, cyc + LAT);
      step(LAT + 2);
    end
    check_int("chain_pulses", pulses - pulse_base, 3);

    step(4);
    check_int("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
